// File: rtl/addr_result_sequencer.sv
// Issue/write-back sequencer for the address add (030/031) and multiply (032) units:
// reserves the destination A register, tracks the fixed unit latency, and drives the A write port.
module addr_result_sequencer #(
    parameter int WIDTH   = 24,
    parameter int NREG    = 8,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_issue_valid,
    input  logic [6:0]               i_instr,
    input  logic [$clog2(NREG)-1:0]  i_dest,
    output logic                     o_issue_ready,
    input  logic [WIDTH-1:0]         i_add_result,
    input  logic [WIDTH-1:0]         i_mul_result,
    output logic                     o_a_we,
    output logic [$clog2(NREG)-1:0]  o_a_waddr,
    output logic [WIDTH-1:0]         o_a_wdata,
    output logic [NREG-1:0]          o_a_busy
);

    localparam int AW = $clog2(NREG);

    localparam logic [6:0] OP_ADD = 7'b0011000;
    localparam logic [6:0] OP_SUB = 7'b0011001;
    localparam logic [6:0] OP_MUL = 7'b0011010;

    typedef enum logic {
        UNIT_ADD = 1'b0,
        UNIT_MUL = 1'b1
    } unit_e;

    typedef struct packed {
        logic           valid;
        unit_e          unit;
        logic [AW-1:0]  dest;
    } slot_t;

    // Slot k holds the completion due k+1 edges from now.
    slot_t [MUL_LAT-1:0] pipe_q, pipe_d;
    logic  [NREG-1:0]    busy_q, busy_d;
    logic                we_q, we_d;
    logic  [AW-1:0]      waddr_q, waddr_d;
    logic  [WIDTH-1:0]   wdata_q, wdata_d;

    logic is_add;
    logic is_mul;
    logic add_slot_free;
    logic accept;
    logic retire;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        is_add = (i_instr == OP_ADD) || (i_instr == OP_SUB);
        is_mul = (i_instr == OP_MUL);

        // After this edge's shift, current slot ADD_LAT becomes the add's target slot.
        // The multiply target lies beyond the current pipe, so it is always free.
        add_slot_free = !pipe_q[ADD_LAT].valid;

        o_issue_ready = ((is_add && add_slot_free) || is_mul) && !busy_q[i_dest];
        accept        = i_issue_valid && o_issue_ready;
        retire        = pipe_q[0].valid;

        for (int k = 0; k < MUL_LAT - 1; k++) begin
            pipe_d[k] = pipe_q[k + 1];
        end
        pipe_d[MUL_LAT-1] = '0;

        if (accept) begin
            if (is_mul) begin
                pipe_d[MUL_LAT-1] = '{valid: 1'b1, unit: UNIT_MUL, dest: i_dest};
            end else begin
                pipe_d[ADD_LAT-1] = '{valid: 1'b1, unit: UNIT_ADD, dest: i_dest};
            end
        end

        we_d    = retire;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;

        if (retire) begin
            waddr_d = pipe_q[0].dest;
            wdata_d = (pipe_q[0].unit == UNIT_MUL) ? i_mul_result : i_add_result;
            busy_d[pipe_q[0].dest] = 1'b0;
        end

        // A retiring register is still busy this cycle, so accept never targets it.
        if (accept) begin
            busy_d[i_dest] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the in-flight pipe is reset too, so results issued before reset are dropped, never written.
            pipe_q  <= '0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            pipe_q  <= pipe_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_a_we    = we_q;
    assign o_a_waddr = waddr_q;
    assign o_a_wdata = wdata_q;
    assign o_a_busy  = busy_q;

endmodule

// File: tb/tb_addr_result_sequencer.sv
// Self-checking bench for addr_result_sequencer: directed scenarios then random traffic
// checked against a pending-result list model with behavioural add/multiply units.
module tb_addr_result_sequencer;

    localparam int WIDTH   = 24;
    localparam int NREG    = 8;
    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 6;

    localparam logic [6:0] OP_ADD = 7'b0011000;
    localparam logic [6:0] OP_SUB = 7'b0011001;
    localparam logic [6:0] OP_MUL = 7'b0011010;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_issue_valid = 1'b0;
    logic [6:0]       i_instr = '0;
    logic [2:0]       i_dest = '0;
    logic             o_issue_ready;
    logic [WIDTH-1:0] i_add_result;
    logic [WIDTH-1:0] i_mul_result;
    logic             o_a_we;
    logic [2:0]       o_a_waddr;
    logic [WIDTH-1:0] o_a_wdata;
    logic [NREG-1:0]  o_a_busy;
    logic [WIDTH-1:0] aj = '0;
    logic [WIDTH-1:0] ak = '0;

    always #5 clk = ~clk;

    addr_result_sequencer #(
        .WIDTH(WIDTH), .NREG(NREG), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_issue_valid(i_issue_valid),
        .i_instr(i_instr),
        .i_dest(i_dest),
        .o_issue_ready(o_issue_ready),
        .i_add_result(i_add_result),
        .i_mul_result(i_mul_result),
        .o_a_we(o_a_we),
        .o_a_waddr(o_a_waddr),
        .o_a_wdata(o_a_wdata),
        .o_a_busy(o_a_busy)
    );

    // Behavioural functional units: result appears LAT edges after the accepting edge,
    // with random junk flowing through when no operation was accepted.
    logic [WIDTH-1:0] add_pipe [ADD_LAT];
    logic [WIDTH-1:0] mul_pipe [MUL_LAT];

    always @(posedge clk) begin
        if (i_issue_valid && o_issue_ready && i_instr == OP_ADD)      add_pipe[0] <= aj + ak;
        else if (i_issue_valid && o_issue_ready && i_instr == OP_SUB) add_pipe[0] <= aj - ak;
        else                                                          add_pipe[0] <= WIDTH'($urandom);
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];

        if (i_issue_valid && o_issue_ready && i_instr == OP_MUL) mul_pipe[0] <= aj * ak;
        else                                                     mul_pipe[0] <= WIDTH'($urandom);
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    assign i_add_result = add_pipe[ADD_LAT-1];
    assign i_mul_result = mul_pipe[MUL_LAT-1];

    // Reference model: list of results in flight, each with its due edge number.
    typedef struct {
        int               due;
        logic [2:0]       dest;
        logic [WIDTH-1:0] data;
    } pend_t;

    pend_t            pend [$];
    int               edge_cnt = 0;
    logic             exp_we = 1'b0;
    logic [2:0]       exp_waddr = '0;
    logic [WIDTH-1:0] exp_wdata = '0;
    logic             last_ready;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [6:0] op);
        if (op == OP_ADD || op == OP_SUB) return ADD_LAT;
        if (op == OP_MUL)                 return MUL_LAT;
        return 0;
    endfunction

    function automatic logic [WIDTH-1:0] op_result(input logic [6:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return a * b;
        endcase
    endfunction

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b = '0;
        foreach (pend[i]) b[pend[i].dest] = 1'b1;
        return b;
    endfunction

    function automatic logic model_ready(input logic [6:0] op, input logic [2:0] d);
        int due;
        if (lat_of(op) == 0) return 1'b0;
        if (model_busy()[d]) return 1'b0;
        due = edge_cnt + 1 + lat_of(op);
        foreach (pend[i]) if (pend[i].due == due) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: present inputs after the falling edge, check ready,
    // advance the model across the rising edge, then check registered outputs.
    task automatic step(input logic v, input logic [6:0] op, input logic [2:0] d,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic exp_rdy;
        i_issue_valid = v;
        i_instr       = op;
        i_dest        = d;
        aj            = a;
        ak            = b;
        #1;
        exp_rdy = model_ready(op, d);
        check("ready", o_issue_ready, exp_rdy);
        last_ready = o_issue_ready;
        @(posedge clk);
        edge_cnt++;
        exp_we = 1'b0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due == edge_cnt) begin
                exp_we    = 1'b1;
                exp_waddr = pend[i].dest;
                exp_wdata = pend[i].data;
                pend.delete(i);
            end
        end
        if (v && exp_rdy) pend.push_back('{due: edge_cnt + lat_of(op), dest: d, data: op_result(op, a, b)});
        @(negedge clk);
        check("we",    o_a_we,    exp_we);
        check("waddr", o_a_waddr, exp_waddr);
        check("wdata", o_a_wdata, exp_wdata);
        check("busy",  o_a_busy,  model_busy());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, OP_BAD, 3'd0, '0, '0);
    endtask

    initial begin
        int blocked;
        logic acc;
        logic [6:0] op;
        int r;

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_we",    o_a_we,    1'b0);
        check("rst_waddr", o_a_waddr, 3'd0);
        check("rst_wdata", o_a_wdata, 24'd0);
        check("rst_busy",  o_a_busy,  8'd0);
        rst_n = 1'b1;

        // 1: add, dest A3 = 2 + 3
        step(1'b1, OP_ADD, 3'd3, 24'd2, 24'd3);
        check("t1_accept", last_ready, 1'b1);
        check("t1_busy3",  o_a_busy[3], 1'b1);
        idle(1);
        check("t1_we_early", o_a_we, 1'b0);
        idle(1);
        check("t1_we",    o_a_we,      1'b1);
        check("t1_waddr", o_a_waddr,   3'd3);
        check("t1_wdata", o_a_wdata,   24'h000005);
        check("t1_busy3_clr", o_a_busy[3], 1'b0);

        // 6: unrecognised opcode leaves everything alone
        step(1'b1, OP_BAD, 3'd2, 24'd7, 24'd7);
        check("t6_ready", last_ready, 1'b0);
        check("t6_busy",  o_a_busy,   8'd0);
        idle(3);

        // 2: sub, 0 - 1 wraps to all ones
        step(1'b1, OP_SUB, 3'd1, 24'd0, 24'd1);
        idle(2);
        check("t2_wdata", o_a_wdata, 24'hFFFFFF);
        idle(2);

        // 3: back-to-back adds write on consecutive edges
        step(1'b1, OP_ADD, 3'd1, 24'd10, 24'd1);
        check("t3_ready_a", last_ready, 1'b1);
        step(1'b1, OP_ADD, 3'd2, 24'd20, 24'd2);
        check("t3_ready_b", last_ready, 1'b1);
        idle(1);
        check("t3_waddr_a", o_a_waddr, 3'd1);
        idle(1);
        check("t3_waddr_b", o_a_waddr, 3'd2);
        check("t3_we_b",    o_a_we,    1'b1);
        idle(3);

        // 4a: reissue to a busy register waits for the busy clear (conservative by one cycle)
        step(1'b1, OP_ADD, 3'd4, 24'd1, 24'd1);
        blocked = 0;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            step(1'b1, OP_ADD, 3'd4, 24'd2, 24'd2);
            if (last_ready) acc = 1'b1;
            else blocked++;
        end
        check("t4_blocked_cycles", blocked, 2);
        idle(4);

        // 4b: add whose completion lands on an in-flight multiply's slot is refused
        step(1'b1, OP_MUL, 3'd0, 24'd3, 24'd4);
        idle(3);
        step(1'b1, OP_ADD, 3'd5, 24'd1, 24'd1);
        check("t4_collide", last_ready, 1'b0);
        idle(8);

        // 5: reset while a multiply is in flight
        step(1'b1, OP_MUL, 3'd6, 24'd5, 24'd6);
        idle(2);
        i_issue_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        pend.delete();
        exp_we = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        check("t5_busy", o_a_busy, 8'd0);
        check("t5_we",   o_a_we,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, OP_ADD, 3'd6, 24'd8, 24'd9);
        check("t5_accept_after_rst", last_ready, 1'b1);
        idle(8);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: op = OP_ADD;
                3, 4:    op = OP_SUB;
                5, 6:    op = OP_MUL;
                7:       op = OP_BAD;
                default: op = 7'($urandom);
            endcase
            step(r != 9, op, 3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
        end
        idle(MUL_LAT + 2);
        check("drain_busy", o_a_busy, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
